// File: rtl/config_loader.sv
// Config frame loader: assembles NUM_INPUTS+1 stream words, then writes them to the regfile.
// Optional build macro CONFIG_LOADER_RETRY_EN adds one retry gap after the first ack timeout.
module config_loader #(
    parameter int WIDTH       = 16,
    parameter int NUM_INPUTS  = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    output logic             s_ready,
    input  logic             abort,
    output logic             cfg_wen,
    output logic             cfg_rev,
    output logic [WIDTH-1:0] cfg_w_data [NUM_INPUTS:0],
    input  logic             cfg_wr_ack,
    output logic             done,
    output logic             err,
    output logic [7:0]       frame_cnt
);
    localparam int IW = $clog2(NUM_INPUTS + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_INPUTS);
    localparam logic [TW-1:0] T_LAST   = TW'(ACK_TIMEOUT - 1);

`ifdef CONFIG_LOADER_RETRY_EN
    typedef enum logic [1:0] {S_FILL, S_WRITE, S_GAP} state_t;
`else
    typedef enum logic [1:0] {S_FILL, S_WRITE} state_t;
`endif

    state_t           r_state, w_state_nx;
    logic [IW-1:0]    r_idx, w_idx_nx;
    logic [TW-1:0]    r_tcnt, w_tcnt_nx;
    logic             r_ready, w_ready_nx;
    logic             r_wen, w_wen_nx;
    logic             r_done, w_done_nx;
    logic             r_err, w_err_nx;
    logic [7:0]       r_cnt, w_cnt_nx;
    logic             r_retried, w_retried_nx;
    logic             w_load;
    logic [WIDTH-1:0] r_data [NUM_INPUTS:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_FILL;
            r_idx     <= '0;
            r_tcnt    <= '0;
            r_ready   <= 1'b1;
            r_wen     <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
            r_retried <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_idx     <= w_idx_nx;
            r_tcnt    <= w_tcnt_nx;
            r_ready   <= w_ready_nx;
            r_wen     <= w_wen_nx;
            r_done    <= w_done_nx;
            r_err     <= w_err_nx;
            r_cnt     <= w_cnt_nx;
            r_retried <= w_retried_nx;
        end
    end

    // Frame buffer survives abort; only reset clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i <= NUM_INPUTS; i++) r_data[i] <= '0;
        end else if (w_load) begin
            r_data[r_idx] <= s_data;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_idx_nx     = r_idx;
        w_tcnt_nx    = r_tcnt;
        w_ready_nx   = r_ready;
        w_wen_nx     = r_wen;
        w_done_nx    = 1'b0;
        w_err_nx     = r_err;
        w_cnt_nx     = r_cnt;
        w_retried_nx = r_retried;
        w_load       = 1'b0;
        if (abort) begin
            w_state_nx   = S_FILL;
            w_idx_nx     = '0;
            w_tcnt_nx    = '0;
            w_ready_nx   = 1'b1;
            w_wen_nx     = 1'b0;
            w_err_nx     = 1'b0;
            w_retried_nx = 1'b0;
        end else begin
            unique case (r_state)
                S_FILL: begin
                    if (s_valid && r_ready) begin
                        w_load = 1'b1;
                        if (r_idx == LAST_IDX) begin
                            w_idx_nx     = '0;
                            w_ready_nx   = 1'b0;
                            w_wen_nx     = 1'b1;
                            w_tcnt_nx    = '0;
                            w_retried_nx = 1'b0;
                            w_state_nx   = S_WRITE;
                        end else begin
                            w_idx_nx = r_idx + IW'(1);
                        end
                    end
                end
                S_WRITE: begin
                    if (cfg_wr_ack) begin
                        w_wen_nx   = 1'b0;
                        w_done_nx  = 1'b1;
                        w_cnt_nx   = r_cnt + 8'd1;
                        w_ready_nx = 1'b1;
                        w_tcnt_nx  = '0;
                        w_state_nx = S_FILL;
                    end else if (r_tcnt == T_LAST) begin
                        w_wen_nx  = 1'b0;
                        w_tcnt_nx = '0;
`ifdef CONFIG_LOADER_RETRY_EN
                        if (!r_retried) begin
                            w_retried_nx = 1'b1;
                            w_state_nx   = S_GAP;
                        end else begin
                            w_err_nx   = 1'b1;
                            w_ready_nx = 1'b1;
                            w_state_nx = S_FILL;
                        end
`else
                        w_err_nx   = 1'b1;
                        w_ready_nx = 1'b1;
                        w_state_nx = S_FILL;
`endif
                    end else begin
                        w_tcnt_nx = r_tcnt + TW'(1);
                    end
                end
`ifdef CONFIG_LOADER_RETRY_EN
                S_GAP: begin
                    w_wen_nx   = 1'b1;
                    w_tcnt_nx  = '0;
                    w_state_nx = S_WRITE;
                end
`endif
                default: begin
                    w_state_nx = S_FILL;
                end
            endcase
        end
    end

    assign s_ready    = r_ready;
    assign cfg_wen    = r_wen;
    assign cfg_rev    = 1'b0;
    assign cfg_w_data = r_data;
    assign done       = r_done;
    assign err        = r_err;
    assign frame_cnt  = r_cnt;

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: fill, ack, timeout, abort, backpressure, wrap, async reset.
module tb_config_loader;
    logic        clk;
    logic        reset_n;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_ready;
    logic        abort;
    logic        cfg_wen;
    logic        cfg_rev;
    logic [15:0] cfg_w_data [8:0];
    logic        cfg_wr_ack;
    logic        done;
    logic        err;
    logic [7:0]  frame_cnt;

    int n_vec = 0;
    int n_err = 0;
    int wen_cyc, done_cyc, rdy_cyc;

    config_loader #(.WIDTH(16), .NUM_INPUTS(8), .ACK_TIMEOUT(15)) dut (
        .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .abort(abort), .cfg_wen(cfg_wen), .cfg_rev(cfg_rev),
        .cfg_w_data(cfg_w_data), .cfg_wr_ack(cfg_wr_ack), .done(done),
        .err(err), .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Words are driven at negedges; each is taken at the following posedge.
    task automatic stream(input logic [15:0] base, input logic [15:0] step,
                          input int n, input bit hold);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = base + 16'(i) * step;
            @(negedge clk);
        end
        s_valid = hold;
        s_data  = hold ? 16'hDEAD : 16'h0000;
    endtask

    // Observes one write burst; ack is raised once wen has been seen ack_after times.
    task automatic run_write(input int ack_after, output int wcyc,
                             output int dcyc, output int rcyc);
        int it;
        wcyc = 0;
        dcyc = 0;
        rcyc = 0;
        for (it = 0; it < 64; it++) begin
            if (cfg_wen) wcyc++;
            if (done) dcyc++;
            if (cfg_wen && s_ready) rcyc++;
            cfg_wr_ack = (ack_after > 0) && cfg_wen && (wcyc == ack_after);
            if (!cfg_wen && wcyc > 0) break;
            @(negedge clk);
        end
        cfg_wr_ack = 1'b0;
        chk("write_bound", 32'(it < 64), 32'd1);
    endtask

    initial begin
        reset_n    = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        abort      = 1'b0;
        cfg_wr_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(s_ready), 32'd1);
        chk("rst_wen", 32'(cfg_wen), 32'd0);
        chk("rst_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rev", 32'(cfg_rev), 32'd0);
        chk("rst_data0", 32'(cfg_w_data[0]), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // ack while filling must be ignored
        cfg_wr_ack = 1'b1;
        @(negedge clk);
        cfg_wr_ack = 1'b0;
        chk("fill_ack_done", 32'(done), 32'd0);
        chk("fill_ack_cnt", 32'(frame_cnt), 32'd0);

        // basic frame, ack on third wen cycle
        stream(16'h1111, 16'h1111, 9, 1'b0);
        chk("f1_wen_rise", 32'(cfg_wen), 32'd1);
        chk("f1_ready_low", 32'(s_ready), 32'd0);
        run_write(3, wen_cyc, done_cyc, rdy_cyc);
        chk("f1_wen_cycles", 32'(wen_cyc), 32'd3);
        chk("f1_done", 32'(done_cyc), 32'd1);
        chk("f1_cnt", 32'(frame_cnt), 32'd1);
        chk("f1_data0", 32'(cfg_w_data[0]), 32'h1111);
        chk("f1_data8", 32'(cfg_w_data[8]), 32'h9999);
        chk("f1_ready", 32'(s_ready), 32'd1);
        @(negedge clk);
        chk("f1_done_pulse", 32'(done), 32'd0);

        // no ack: timeout
        stream(16'h2000, 16'h0001, 9, 1'b0);
        run_write(0, wen_cyc, done_cyc, rdy_cyc);
        chk("to_wen_cycles", 32'(wen_cyc), 32'd15);
`ifdef CONFIG_LOADER_RETRY_EN
        chk("to_gap_err", 32'(err), 32'd0);
        @(negedge clk);
        chk("to_regen", 32'(cfg_wen), 32'd1);
        run_write(0, wen_cyc, done_cyc, rdy_cyc);
        chk("to_retry_cycles", 32'(wen_cyc), 32'd15);
`endif
        chk("to_err", 32'(err), 32'd1);
        chk("to_done", 32'(done_cyc), 32'd0);
        chk("to_cnt", 32'(frame_cnt), 32'd1);
        chk("to_ready", 32'(s_ready), 32'd1);
        @(negedge clk);
        chk("to_err_sticky", 32'(err), 32'd1);

        // abort after 4 words, then a clean frame
        stream(16'hB000, 16'h0001, 4, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_err_clr", 32'(err), 32'd0);
        chk("ab_data_kept", 32'(cfg_w_data[0]), 32'hB000);
        stream(16'hA000, 16'h0001, 9, 1'b0);
        run_write(1, wen_cyc, done_cyc, rdy_cyc);
        chk("ab_data0", 32'(cfg_w_data[0]), 32'hA000);
        chk("ab_data8", 32'(cfg_w_data[8]), 32'hA008);
        chk("ab_wen_cycles", 32'(wen_cyc), 32'd1);
        chk("ab_cnt", 32'(frame_cnt), 32'd2);

        // valid held during write: nothing consumed until commit
        stream(16'hC000, 16'h0001, 9, 1'b1);
        run_write(2, wen_cyc, done_cyc, rdy_cyc);
        chk("bp_ready_low", 32'(rdy_cyc), 32'd0);
        chk("bp_data0_hold", 32'(cfg_w_data[0]), 32'hC000);
        chk("bp_data8_hold", 32'(cfg_w_data[8]), 32'hC008);
        chk("bp_cnt", 32'(frame_cnt), 32'd3);
        @(negedge clk);
        s_valid = 1'b0;
        chk("bp_next_idx0", 32'(cfg_w_data[0]), 32'hDEAD);
        chk("bp_idx1_kept", 32'(cfg_w_data[1]), 32'hC001);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;

        // ack and abort together: abort wins
        stream(16'hE000, 16'h0001, 9, 1'b0);
        cfg_wr_ack = 1'b1;
        abort      = 1'b1;
        @(negedge clk);
        cfg_wr_ack = 1'b0;
        abort      = 1'b0;
        chk("aa_done", 32'(done), 32'd0);
        chk("aa_wen", 32'(cfg_wen), 32'd0);
        chk("aa_cnt", 32'(frame_cnt), 32'd3);
        chk("aa_ready", 32'(s_ready), 32'd1);

        // frame counter wrap
        for (int f = 0; f < 252; f++) begin
            stream(16'(f), 16'h0001, 9, 1'b0);
            run_write(1, wen_cyc, done_cyc, rdy_cyc);
        end
        chk("wrap_255", 32'(frame_cnt), 32'd255);
        stream(16'h5000, 16'h0001, 9, 1'b0);
        run_write(1, wen_cyc, done_cyc, rdy_cyc);
        chk("wrap_0", 32'(frame_cnt), 32'd0);
        chk("wrap_done", 32'(done_cyc), 32'd1);

        // async reset while wen is high
        stream(16'h6000, 16'h0001, 9, 1'b0);
        chk("ar_wen_pre", 32'(cfg_wen), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_wen_drop", 32'(cfg_wen), 32'd0);
        chk("ar_ready", 32'(s_ready), 32'd1);
        chk("ar_data_clr", 32'(cfg_w_data[8]), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("ar_wen_stay", 32'(cfg_wen), 32'd0);
        chk("ar_cnt", 32'(frame_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
